// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encoding, lsb_size byte counts and IO window constants for mem_ctrl.
// MEM_CTRL_RR_EN selects round-robin arbitration instead of fixed LSB-first priority.
package mem_ctrl_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] IC_RD = 2'd1;
   localparam logic [1:0] LS_RD = 2'd2;
   localparam logic [1:0] LS_WR = 2'd3;
   localparam logic [1:0] SZ_B  = 2'd0;
   localparam logic [1:0] SZ_H  = 2'd1;
   localparam logic [31:0] IO_BASE = 32'h0003_0000;
   localparam logic [31:0] IO_SPAN = 32'd8;
`ifdef MEM_CTRL_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif
   // codes 2 and 3 both mean a 4-byte word
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      return sz == SZ_B ? 3'd1 : sz == SZ_H ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: IDLE-time grant between icache refill and LSB, masking a requester during its done cycle.
// MEM_CTRL_RR_EN: round-robin on ties; otherwise the LSB always wins.
module mem_ctrl_arb
   import mem_ctrl_pkg::*;
(
   input  logic clk_in,
   input  logic rst_in,
   input  logic rdy_in,
   input  logic idle,
   input  logic rob_clear,
   input  logic ic_req,
   input  logic ic_done,
   input  logic lsb_req,
   input  logic lsb_done,
   output logic gnt_ic,
   output logic gnt_lsb
);
   logic last_lsb_q, last_lsb_d, en, ic_v, lsb_v;
   always_comb begin
      en         = rdy_in && idle && !rob_clear;
      ic_v       = ic_req && !ic_done;
      lsb_v      = lsb_req && !lsb_done;
      gnt_lsb    = en && lsb_v && (!ic_v || !RR_EN || !last_lsb_q);
      gnt_ic     = en && ic_v && !gnt_lsb;
      last_lsb_d = gnt_lsb || (last_lsb_q && !gnt_ic);
   end
   always_ff @(posedge clk_in)
      if (rst_in) last_lsb_q <= 1'b0;
      else        last_lsb_q <= last_lsb_d;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM port sequencer shared by icache refill and the load/store buffer.
// Arbitration mode is chosen by MEM_CTRL_RR_EN (see mem_ctrl_arb).
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int          LINE_BYTES = 16,
   parameter logic [31:0] IO_ADDR    = IO_BASE
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic [7:0]              mem_din,
   output logic [7:0]              mem_dout,
   output logic [31:0]             mem_a,
   output logic                    mem_wr,
   input  logic                    io_buffer_full,
   input  logic                    ic_req,
   input  logic [31:0]             ic_addr,
   output logic                    ic_done,
   output logic [LINE_BYTES*8-1:0] ic_data,
   input  logic                    lsb_req,
   input  logic                    lsb_we,
   input  logic [1:0]              lsb_size,
   input  logic [31:0]             lsb_addr,
   input  logic [31:0]             lsb_wdata,
   output logic                    lsb_done,
   output logic [31:0]             lsb_rdata,
   input  logic                    rob_clear
);
   localparam int CW = $clog2(LINE_BYTES) + 1;
   logic [1:0] state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, n;
   logic [LINE_BYTES*8-1:0] buf_q, buf_d, ic_data_q, ic_data_d;
   logic [31:0] lsb_rdata_q, lsb_rdata_d, base, addr;
   logic ic_done_q, ic_done_d, lsb_done_q, lsb_done_d, gnt_ic, gnt_lsb, rd, stall;
   logic [7:0] wr_byte;

   mem_ctrl_arb u_arb (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .idle     (state_q == IDLE),
      .rob_clear(rob_clear),
      .ic_req   (ic_req),
      .ic_done  (ic_done_q),
      .lsb_req  (lsb_req),
      .lsb_done (lsb_done_q),
      .gnt_ic   (gnt_ic),
      .gnt_lsb  (gnt_lsb)
   );

   always_comb begin
      base    = state_q == IC_RD ? ic_addr : lsb_addr;
      n       = state_q == IC_RD ? CW'(LINE_BYTES) : CW'(size_bytes(lsb_size));
      addr    = base + 32'(cnt_q);
      rd      = state_q == IC_RD || state_q == LS_RD;
      stall   = (addr - IO_ADDR) < IO_SPAN && io_buffer_full;
      wr_byte = 8'h00;
      for (int i = 0; i < 4; i++) if (cnt_q == CW'(i)) wr_byte = lsb_wdata[8*i +: 8];
      state_d    = state_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      ic_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      if (gnt_ic || gnt_lsb) begin
         state_d = gnt_ic ? IC_RD : lsb_we ? LS_WR : LS_RD;
         buf_d   = '0;
      end else if (rd && rob_clear) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (rd) begin
         // mem_din lags the address by one cycle, so count k stores byte k-1
         for (int i = 0; i < LINE_BYTES; i++) if (cnt_q == CW'(i + 1)) buf_d[8*i +: 8] = mem_din;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == n) begin
            state_d    = IDLE;
            cnt_d      = '0;
            ic_done_d  = state_q == IC_RD;
            lsb_done_d = state_q == LS_RD;
         end
      end else if (state_q == LS_WR && !stall) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == n - 1'b1) begin
            state_d    = IDLE;
            cnt_d      = '0;
            lsb_done_d = 1'b1;
         end
      end
      ic_data_d   = ic_done_d ? buf_d : ic_data_q;
      lsb_rdata_d = lsb_done_d && state_q == LS_RD ? buf_d[31:0] : lsb_rdata_q;
   end

   always_ff @(posedge clk_in)
      if (rst_in) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         buf_q       <= '0;
         ic_data_q   <= '0;
         lsb_rdata_q <= '0;
         ic_done_q   <= 1'b0;
         lsb_done_q  <= 1'b0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         ic_data_q   <= ic_data_d;
         lsb_rdata_q <= lsb_rdata_d;
         ic_done_q   <= ic_done_d;
         lsb_done_q  <= lsb_done_d;
      end

   assign mem_a     = state_q == IDLE ? 32'h0 : addr;
   assign mem_dout  = state_q == LS_WR ? wr_byte : 8'h00;
   assign mem_wr    = rdy_in && state_q == LS_WR && !stall;
   assign ic_done   = ic_done_q;
   assign ic_data   = ic_data_q;
   assign lsb_done  = lsb_done_q;
   assign lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized scenarios for mem_ctrl checked against a byte-addressed RAM model and
// latency rules (read N+2, write N+1 cycles from request). Honors MEM_CTRL_RR_EN.
module tb_mem_ctrl;
   localparam int LB = 16;
`ifdef MEM_CTRL_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk_in = 1'b0, rst_in, rdy_in, io_buffer_full, ic_req, lsb_req, lsb_we, rob_clear;
   logic mem_wr, ic_done, lsb_done;
   logic [7:0] mem_din, mem_dout;
   logic [31:0] mem_a, ic_addr, lsb_addr, lsb_wdata, lsb_rdata;
   logic [1:0] lsb_size;
   logic [LB*8-1:0] ic_data;
   int errors = 0, checks = 0, both_done = 0, ic_pulses = 0;
   logic [7:0] ram [logic [31:0]];
   logic [39:0] wlog [$];

   always #5 clk_in = ~clk_in;

   mem_ctrl #(.LINE_BYTES(LB)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .ic_req(ic_req),
      .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data), .lsb_req(lsb_req), .lsb_we(lsb_we),
      .lsb_size(lsb_size), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done),
      .lsb_rdata(lsb_rdata), .rob_clear(rob_clear)
   );

   function automatic logic [7:0] rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 8'h00;
   endfunction

   function automatic int nb(input logic [1:0] s);
      return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
   endfunction

   // synchronous RAM; its port is frozen together with the controller while rdy_in is low
   always @(posedge clk_in) begin
      if (rdy_in) mem_din <= rd(mem_a);
      if (mem_wr) begin
         ram[mem_a] = mem_dout;
         wlog.push_back({mem_a, mem_dout});
      end
   end

   always @(negedge clk_in) begin
      if (ic_done && lsb_done) both_done++;
      if (ic_done) ic_pulses++;
   end

   task automatic xact(input bit ic, input bit we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int full_k, input int rob_at, input int rdy_at,
                       output int lat, output int nwr);
      lat = -1;
      nwr = 0;
      for (int i = 0; i <= 60; i++) begin
         @(negedge clk_in);
         if (i == 0) begin
            if (ic) begin ic_req = 1; ic_addr = a; end
            else begin lsb_req = 1; lsb_we = we; lsb_size = sz; lsb_addr = a; lsb_wdata = wd; end
         end
         io_buffer_full = i >= 1 && i <= full_k;
         rob_clear = i == rob_at;
         rdy_in = !(rdy_at >= 0 && i >= rdy_at && i < rdy_at + 2);
         if (i == rob_at && i > 0 && !we) begin ic_req = 0; lsb_req = 0; end
         #1;
         if (mem_wr) nwr++;
         if (ic ? ic_done : lsb_done) begin lat = i; break; end
      end
      ic_req = 0; lsb_req = 0; rob_clear = 0; io_buffer_full = 0; rdy_in = 1;
   endtask

   task automatic both(input logic [31:0] ia, input bit we, input logic [1:0] sz,
                       input logic [31:0] la, input logic [31:0] wd, output int t_ic, output int t_ls);
      t_ic = -1;
      t_ls = -1;
      for (int i = 0; i <= 80 && (t_ic < 0 || t_ls < 0); i++) begin
         @(negedge clk_in);
         if (i == 0) begin
            ic_req = 1; ic_addr = ia;
            lsb_req = 1; lsb_we = we; lsb_size = sz; lsb_addr = la; lsb_wdata = wd;
         end
         #1;
         if (ic_done && t_ic < 0) begin t_ic = i; ic_req = 0; end
         if (lsb_done && t_ls < 0) begin t_ls = i; lsb_req = 0; end
      end
      ic_req = 0; lsb_req = 0;
   endtask

   task automatic test_reset();
      rst_in = 1;
      repeat (3) @(negedge clk_in);
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
      checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h exp 0", mem_a); end
      checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got %h exp 0", mem_dout); end
      checks++; if ({ic_done, lsb_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", {ic_done, lsb_done}); end
      checks++; if (lsb_rdata !== 32'h0 || ic_data !== '0) begin errors++; $display("FAIL reset_data got %h/%h exp 0", lsb_rdata, ic_data); end
      rst_in = 0;
   endtask

   task automatic test_load();
      int lat, nwr, n;
      logic [31:0] a, e;
      logic [1:0] sz;
      ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
      xact(0, 0, 2'd2, 32'h100, 0, 0, -1, -1, lat, nwr);
      checks++; if (lsb_rdata !== 32'h44332211) begin errors++; $display("FAIL load_word got %h exp 44332211", lsb_rdata); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL load_latency got %0d exp 6", lat); end
      checks++; if (nwr !== 0) begin errors++; $display("FAIL load_no_write got %0d exp 0", nwr); end
      for (int t = 0; t < 8; t++) begin
         a = t == 7 ? 32'hFFFF_FFFE : 32'($urandom_range(32'h1000, 32'h1FFF));
         sz = 2'($urandom_range(0, 3));
         n = nb(sz);
         e = 0;
         for (int k = 0; k < 4; k++) ram[a + 32'(k)] = 8'($urandom);
         for (int k = 0; k < n; k++) e[8*k +: 8] = rd(a + 32'(k));
         xact(0, 0, sz, a, 0, 0, -1, -1, lat, nwr);
         checks++; if (lsb_rdata !== e) begin errors++; $display("FAIL rand_load @%h sz%0d got %h exp %h", a, sz, lsb_rdata, e); end
         checks++; if (lat !== n + 2) begin errors++; $display("FAIL rand_load_lat got %0d exp %0d", lat, n + 2); end
      end
   endtask

   task automatic test_store();
      int lat, nwr, n;
      logic [31:0] a, wd;
      logic [1:0] sz;
      for (int t = 0; t < 8; t++) begin
         a = t == 7 ? 32'hFFFF_FFFF : 32'($urandom_range(32'h2000, 32'h2FFF));
         sz = t == 7 ? 2'd3 : 2'($urandom_range(0, 3));
         wd = $urandom;
         n = nb(sz);
         wlog.delete();
         xact(0, 1, sz, a, wd, 0, -1, -1, lat, nwr);
         checks++; if (lat !== n + 1) begin errors++; $display("FAIL store_lat got %0d exp %0d", lat, n + 1); end
         checks++; if (wlog.size() !== n) begin errors++; $display("FAIL store_count got %0d exp %0d", wlog.size(), n); end
         for (int k = 0; k < n && k < wlog.size(); k++) begin
            checks++;
            if (wlog[k] !== {a + 32'(k), wd[8*k +: 8]}) begin
               errors++; $display("FAIL store_byte%0d got %h exp %h", k, wlog[k], {a + 32'(k), wd[8*k +: 8]});
            end
         end
      end
   endtask

   task automatic test_refill();
      int lat, nwr;
      logic [31:0] ia;
      logic [LB*8-1:0] e;
      for (int t = 0; t < 3; t++) begin
         ia = 32'($urandom_range(16, 255)) * LB;
         for (int k = 0; k < LB; k++) begin ram[ia + 32'(k)] = 8'($urandom); e[8*k +: 8] = rd(ia + 32'(k)); end
         xact(1, 0, 0, ia, 0, 0, -1, -1, lat, nwr);
         checks++; if (ic_data !== e) begin errors++; $display("FAIL refill_data @%h got %h exp %h", ia, ic_data, e); end
         checks++; if (lat !== LB + 2) begin errors++; $display("FAIL refill_lat got %0d exp %0d", lat, LB + 2); end
      end
   endtask

   task automatic test_priority();
      int lat, nwr, t_ic, t_ls, p0;
      logic [LB*8-1:0] e;
      xact(1, 0, 0, 32'h0, 0, 0, -1, -1, lat, nwr);
      for (int k = 0; k < LB; k++) begin ram[32'(k)] = 8'($urandom); e[8*k +: 8] = rd(32'(k)); end
      wlog.delete();
      p0 = ic_pulses;
      both(32'h0, 1, 2'd0, 32'h200, 32'h0000_00AB, t_ic, t_ls);
      repeat (3) @(negedge clk_in);
      checks++; if (t_ls !== 2) begin errors++; $display("FAIL prio_lsb_first got %0d exp 2", t_ls); end
      checks++; if (t_ic !== LB + 4) begin errors++; $display("FAIL prio_ic_after got %0d exp %0d", t_ic, LB + 4); end
      checks++; if (wlog.size() !== 1 || wlog[0] !== {32'h200, 8'hAB}) begin errors++; $display("FAIL prio_write got n=%0d %h exp 1 00000200ab", wlog.size(), wlog.size() ? wlog[0] : 40'h0); end
      checks++; if (ic_data !== e) begin errors++; $display("FAIL prio_refill got %h exp %h", ic_data, e); end
      checks++; if (ic_pulses - p0 !== 1) begin errors++; $display("FAIL prio_ic_once got %0d exp 1", ic_pulses - p0); end
   endtask

   task automatic test_rr_tie();
      int lat, nwr, t_ic, t_ls, e_ic, e_ls;
      xact(0, 0, 2'd0, 32'h10, 0, 0, -1, -1, lat, nwr);
      both(32'h40, 0, 2'd0, 32'h20, 0, t_ic, t_ls);
      e_ic = RR ? LB + 2 : 3 + LB + 2;
      e_ls = RR ? LB + 2 + 3 : 3;
      checks++; if (t_ic !== e_ic || t_ls !== e_ls) begin errors++; $display("FAIL tie_order got ic=%0d lsb=%0d exp ic=%0d lsb=%0d", t_ic, t_ls, e_ic, e_ls); end
   endtask

   task automatic test_rob();
      int lat, nwr, p0, found;
      logic [31:0] wd;
      p0 = ic_pulses;
      found = 0;
      @(negedge clk_in);
      ic_addr = 32'h40; ic_req = 1;
      for (int i = 0; i < 30 && found == 0; i++) begin
         #1;
         if (mem_a === 32'h45) begin found = 1; rob_clear = 1; ic_req = 0; end
         else @(negedge clk_in);
      end
      @(negedge clk_in);
      rob_clear = 0; ic_req = 0;
      #1;
      checks++; if (found !== 1) begin errors++; $display("FAIL rob_reach_byte5 got %0d exp 1", found); end
      checks++; if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin errors++; $display("FAIL rob_idle got a=%h wr=%b exp 0/0", mem_a, mem_wr); end
      repeat (25) @(negedge clk_in);
      checks++; if (ic_pulses !== p0) begin errors++; $display("FAIL rob_no_ic_done got %0d exp 0", ic_pulses - p0); end
      wd = $urandom;
      wlog.delete();
      xact(0, 1, 2'd2, 32'h300, wd, 0, 2, -1, lat, nwr);
      checks++; if (lat !== 5 || nwr !== 4) begin errors++; $display("FAIL rob_store got lat=%0d n=%0d exp 5/4", lat, nwr); end
      checks++; if (wlog.size() !== 4 || wlog[3] !== {32'h303, wd[31:24]}) begin errors++; $display("FAIL rob_store_bytes got n=%0d exp 4", wlog.size()); end
      ram[32'h100] = 8'h11;
      xact(0, 0, 2'd0, 32'h100, 0, 0, 0, -1, lat, nwr);
      checks++; if (lat !== 4 || lsb_rdata !== 32'h11) begin errors++; $display("FAIL rob_idle_nogrant got lat=%0d d=%h exp 4/00000011", lat, lsb_rdata); end
      xact(0, 0, 2'd2, 32'h100, 0, 0, 3, -1, lat, nwr);
      checks++; if (lat !== -1 || lsb_rdata !== 32'h11) begin errors++; $display("FAIL rob_load_abort got lat=%0d d=%h exp -1/00000011", lat, lsb_rdata); end
   endtask

   task automatic test_io();
      int lat, nwr;
      logic [31:0] at [4] = '{32'h3_0000, 32'h3_0007, 32'h3_0008, 32'h2_FFFF};
      int fk [4] = '{3, 2, 2, 2};
      int el [4] = '{5, 4, 2, 2};
      for (int t = 0; t < 4; t++) begin
         wlog.delete();
         xact(0, 1, 2'd0, at[t], 32'h5A, fk[t], -1, -1, lat, nwr);
         checks++; if (lat !== el[t] || nwr !== 1) begin errors++; $display("FAIL io_store @%h got lat=%0d n=%0d exp %0d/1", at[t], lat, nwr, el[t]); end
         checks++; if (wlog.size() !== 1 || wlog[0] !== {at[t], 8'h5A}) begin errors++; $display("FAIL io_store_data @%h got n=%0d", at[t], wlog.size()); end
      end
   endtask

   task automatic test_rdy();
      int lat, nwr;
      logic [31:0] e, wd;
      e = 0;
      for (int k = 0; k < 4; k++) begin ram[32'h180 + 32'(k)] = 8'($urandom); e[8*k +: 8] = rd(32'h180 + 32'(k)); end
      xact(0, 0, 2'd2, 32'h180, 0, 0, -1, 3, lat, nwr);
      checks++; if (lsb_rdata !== e || lat !== 8) begin errors++; $display("FAIL rdy_load got %h lat=%0d exp %h lat=8", lsb_rdata, lat, e); end
      for (int r = 1; r <= 2; r++) begin
         wd = $urandom;
         wlog.delete();
         xact(0, 1, 2'd2, 32'h400, wd, 0, -1, r, lat, nwr);
         checks++; if (lat !== 7 || wlog.size() !== 4) begin errors++; $display("FAIL rdy_store got lat=%0d n=%0d exp 7/4", lat, wlog.size()); end
         for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            checks++; if (wlog[k] !== {32'h400 + 32'(k), wd[8*k +: 8]}) begin errors++; $display("FAIL rdy_store_byte%0d got %h", k, wlog[k]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit seq [$];
      @(negedge clk_in);
      ic_req = 1; ic_addr = 32'h80;
      lsb_req = 1; lsb_we = 0; lsb_size = 2'd0; lsb_addr = 32'h50;
      for (int i = 0; i < 200 && seq.size() < 6; i++) begin
         @(negedge clk_in);
         #1;
         if (ic_done) seq.push_back(1'b1);
         if (lsb_done) seq.push_back(1'b0);
      end
      ic_req = 0; lsb_req = 0;
      checks++; if (seq.size() !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", seq.size()); end
      for (int k = 1; k < seq.size(); k++) begin
         checks++; if (seq[k] === seq[k-1]) begin errors++; $display("FAIL b2b_alternate at %0d got %b twice", k, seq[k]); end
      end
      repeat (4) @(negedge clk_in);
      checks++; if (both_done !== 0) begin errors++; $display("FAIL both_done got %0d exp 0", both_done); end
   endtask

   initial begin
      rst_in = 1; rdy_in = 1; io_buffer_full = 0; ic_req = 0; lsb_req = 0; lsb_we = 0; rob_clear = 0;
      ic_addr = 0; lsb_addr = 0; lsb_wdata = 0; lsb_size = 0;
      test_reset();
      test_load();
      test_store();
      test_refill();
      test_priority();
      test_rr_tie();
      test_rob();
      test_io();
      test_rdy();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
